frame_buffer: RTL and testbench
===============================

# frame_buffer

Downstream consumer of the frame-checker state machine. Takes the checker's per-cycle word, sequence count and error flag, tentatively stores each frame's words in a circular buffer, and commits them only when the frame completes cleanly. On an error, sequence break or overflow it discards the partial frame. The downstream reader sees only committed words, through a simple read-enable port.

## Interface
- DEPTH, 16, buffer capacity in 16-bit words; power of two, ≥ FRAME_LEN
- FRAME_LEN, 4, words per frame; legal range 2..DEPTH
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  checker word valid this cycle
- in_data  in  16  checker bus_out word
- in_seq  in  4  checker control (sequence number of word)
- in_error  in  1  checker error flag, qualified by in_valid
- rd_en  in  1  read request from consumer
- out_data  out  16  read word, registered
- out_valid  out  1  one-cycle pulse, out_data valid
- count  out  log2(DEPTH)+1  committed words available
- empty  out  1  count == 0
- full  out  1  written-but-unread words (committed + tentative) == DEPTH
- drop_cnt  out  8  discarded frames, saturates at 255
- overflow  out  1  one-cycle pulse when a frame is dropped for lack of space

## Operation
- Pointers are log2(DEPTH)+1 bits wide, with wrap bit: rd_ptr, commit_ptr, wr_ptr. Invariant: rd_ptr ≤ commit_ptr ≤ wr_ptr (modulo).
- count = commit_ptr − rd_ptr. Space = DEPTH − (wr_ptr − rd_ptr), using rd_ptr before this cycle's read.
- An accepted word is a cycle with in_valid=1. Cycles with in_valid=0 are ignored by the FSM.
- FSM states: IDLE, COLLECT, DISCARD. Reset state is IDLE.
- IDLE:
  - Accepted word with in_error=0, in_seq=0 and space>0: write it, set expected seq to 1, go to COLLECT.
  - Same word with space=0: overflow pulse, drop_cnt+1, go to DISCARD.
  - Any other word: ignored, stay in IDLE, no count change.
- COLLECT, accepted word:
  - in_error=1, or in_seq ≠ expected: wr_ptr←commit_ptr (rollback), drop_cnt+1, go to DISCARD.
  - Else, space=0: rollback, overflow pulse, drop_cnt+1, go to DISCARD.
  - Else: write the word and increment expected. If in_seq = FRAME_LEN−1: commit_ptr←wr_ptr+1, go to IDLE.
- DISCARD: ignores words until an accepted word with in_error=0 and in_seq=0. That word is handled exactly as in IDLE in the same cycle (restart without a lost cycle).
- Read: rd_en=1 and count>0 → out_data←mem[rd_ptr], rd_ptr+1, out_valid=1 next cycle. rd_en with count=0 is ignored: no pulse, out_data holds.
- Simultaneous read and commit are both applied the same cycle; count reflects both.
- Rollback never touches committed words or rd_ptr.
- drop_cnt holds at 255 once saturated.

## Timing
- Reset values: out_data=0, out_valid=0, count=0, empty=1, full=0, drop_cnt=0, overflow=0. All pointers are 0 and state is IDLE.
- Reset asserted mid-frame discards everything immediately (asynchronous). The first word accepted after deassertion is evaluated from IDLE.
- Write latency: a committed frame's words appear in count and empty on the cycle after its last word is sampled.
- Read latency: 1 cycle from rd_en to out_valid/out_data.
- overflow pulses for exactly one cycle. drop_cnt updates on the same edge.
- count, empty and full are registered-state derived: no combinational path from in_* or rd_en.

## Test plan
- Clean frame (DEPTH=16, FRAME_LEN=4): words 0xFAE0/seq0, 0xFAE1/seq1, 0xF0E2/seq2, 0xFA03/seq3 → count=4 and empty=0 one cycle after the last word. Four rd_en cycles return the words in order, out_valid one cycle after each rd_en; then empty=1.
- Error frame: seq0..2 clean, then 0xF004 with in_error=1 → count stays 0, drop_cnt=1, state DISCARD. A following clean frame 0xFAE0..0x0AE3 commits, count=4.
- Sequence break: seq0, seq1, seq3 with no error → rollback, drop_cnt=1, count unchanged. A seq0 word in the same stream restarts collection without a lost cycle.
- Overflow: commit 4 clean frames (count=16, full=1), then send a seq0 word → overflow pulses 1 cycle, drop_cnt=1, count=16. After 4 reads, a new frame commits again.
- Reset mid-frame: two words written, then reset asserted between edges → all outputs reach reset values immediately. A subsequent clean frame yields count=4.
- Simultaneous: count=4, rd_en held high while a new frame's last word arrives → on that edge, one read and four commits apply, giving count=7 next cycle and out_valid pulsing each cycle.

Source files
------------

// File: rtl/frame_buffer.sv
// Circular frame buffer fed by the frame checker: words are written tentatively and
// become visible to the reader only when their frame completes with no error or sequence gap.
module frame_buffer #(
  parameter int DEPTH     = 16,
  parameter int FRAME_LEN = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int PW = AW + 1
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          in_valid_i,
  input  logic [15:0]   in_data_i,
  input  logic [3:0]    in_seq_i,
  input  logic          in_error_i,
  input  logic          rd_en_i,
  output logic [15:0]   out_data_o,
  output logic          out_valid_o,
  output logic [PW-1:0] count_o,
  output logic          empty_o,
  output logic          full_o,
  output logic [7:0]    drop_cnt_o,
  output logic          overflow_o
);

  typedef enum logic [1:0] {IDLE, COLLECT, DISCARD} state_e;

  localparam logic [PW-1:0] DEPTH_W  = PW'(DEPTH);
  localparam logic [3:0]    LAST_SEQ = 4'(FRAME_LEN - 1);

  logic [15:0]   mem_q [DEPTH];
  state_e        state_q, state_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] commit_ptr_q, commit_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [3:0]    exp_seq_q, exp_seq_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;
  logic          overflow_q, overflow_d;
  logic          out_valid_q, out_valid_d;
  logic [15:0]   out_data_q, out_data_d;

  logic [PW-1:0] used;
  logic [PW-1:0] avail;
  logic          has_space;
  logic          start_ok;
  logic          wr_en;
  logic          drop_frame;
  logic          rd_fire;

  // used counts committed plus tentative words, so space is checked against the whole
  // unread region, using the read pointer from before this cycle's read.
  assign used      = wr_ptr_q - rd_ptr_q;
  assign avail     = commit_ptr_q - rd_ptr_q;
  assign has_space = (used != DEPTH_W);
  assign start_ok  = in_valid_i && !in_error_i && (in_seq_i == 4'd0);
  assign rd_fire   = rd_en_i && (avail != '0);

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    exp_seq_d    = exp_seq_q;
    overflow_d   = 1'b0;
    drop_frame   = 1'b0;
    wr_en        = 1'b0;
    case (state_q)
      IDLE, DISCARD: begin
        if (start_ok) begin
          if (has_space) begin
            wr_en     = 1'b1;
            wr_ptr_d  = wr_ptr_q + 1'b1;
            exp_seq_d = 4'd1;
            state_d   = COLLECT;
          end else begin
            overflow_d = 1'b1;
            drop_frame = 1'b1;
            state_d    = DISCARD;
          end
        end
      end
      COLLECT: begin
        if (in_valid_i) begin
          if (in_error_i || (in_seq_i != exp_seq_q)) begin
            wr_ptr_d   = commit_ptr_q;
            drop_frame = 1'b1;
            state_d    = DISCARD;
          end else if (!has_space) begin
            wr_ptr_d   = commit_ptr_q;
            overflow_d = 1'b1;
            drop_frame = 1'b1;
            state_d    = DISCARD;
          end else begin
            wr_en     = 1'b1;
            wr_ptr_d  = wr_ptr_q + 1'b1;
            exp_seq_d = exp_seq_q + 4'd1;
            if (in_seq_i == LAST_SEQ) begin
              commit_ptr_d = wr_ptr_q + 1'b1;
              state_d      = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reads only ever see committed words, so they never collide with the write address.
  always_comb begin
    rd_ptr_d    = rd_ptr_q + PW'(rd_fire);
    out_valid_d = rd_fire;
    out_data_d  = rd_fire ? mem_q[rd_ptr_q[AW-1:0]] : out_data_q;
    drop_cnt_d  = (drop_frame && (drop_cnt_q != 8'hFF)) ? drop_cnt_q + 8'd1 : drop_cnt_q;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      rd_ptr_q     <= '0;
      commit_ptr_q <= '0;
      wr_ptr_q     <= '0;
      exp_seq_q    <= '0;
      drop_cnt_q   <= '0;
      overflow_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      rd_ptr_q     <= rd_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      exp_seq_q    <= exp_seq_d;
      drop_cnt_q   <= drop_cnt_d;
      overflow_q   <= overflow_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[AW-1:0]] <= in_data_i;
    end
  end

  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;
  assign count_o     = avail;
  assign empty_o     = (avail == '0);
  assign full_o      = (used == DEPTH_W);
  assign drop_cnt_o  = drop_cnt_q;
  assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_frame_buffer.sv
// Scenario bench for frame_buffer: committed words go into a scoreboard queue as frames
// are driven and are popped against out_data whenever a read produces a word.
module tb_frame_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic [3:0]  in_seq = '0;
  logic        in_error = 1'b0;
  logic        rd_en = 1'b0;
  logic [15:0] out_data;
  logic        out_valid;
  logic [4:0]  count;
  logic        empty;
  logic        full;
  logic [7:0]  drop_cnt;
  logic        overflow;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] expQ[$];
  logic [15:0] expWord;

  frame_buffer #(.DEPTH(16), .FRAME_LEN(4)) dut (
    .clk_i(clk), .reset_i(reset), .in_valid_i(in_valid), .in_data_i(in_data),
    .in_seq_i(in_seq), .in_error_i(in_error), .rd_en_i(rd_en),
    .out_data_o(out_data), .out_valid_o(out_valid), .count_o(count),
    .empty_o(empty), .full_o(full), .drop_cnt_o(drop_cnt), .overflow_o(overflow)
  );

  always #5 clk = ~clk;

  // One clock of stimulus, driven after a falling edge; outputs are settled at the next falling edge.
  task automatic applyStimulus(input logic v, input logic [15:0] d, input logic [3:0] s,
                               input logic e, input logic r);
    in_valid = v; in_data = d; in_seq = s; in_error = e; rd_en = r;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_error = 1'b0; rd_en = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    expQ.delete();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({out_data, out_valid, count, empty, full, drop_cnt, overflow} !== {16'h0, 1'b0, 5'd0, 1'b1, 1'b0, 8'd0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset_values: got data=%h v=%b cnt=%0d e=%b f=%b drop=%0d ovf=%b",
               out_data, out_valid, count, empty, full, drop_cnt, overflow);
    end
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(0, 16'h0, 4'd0, 0, 0);
    checks++;
    if ({count, empty} !== {5'd0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL post_reset: got cnt=%0d empty=%b expected 0/1", count, empty);
    end
  endtask

  task automatic test_clean_frame();
    doReset();
    applyStimulus(1, 16'h1234, 4'd2, 0, 0);
    checks++;
    if ({count, drop_cnt} !== {5'd0, 8'd0}) begin
      errors++;
      $display("[TB] FAIL idle_ignore: got cnt=%0d drop=%0d expected 0/0", count, drop_cnt);
    end
    applyStimulus(1, 16'hFAE0, 4'd0, 0, 0);
    applyStimulus(1, 16'hFAE1, 4'd1, 0, 0);
    applyStimulus(1, 16'hF0E2, 4'd2, 0, 0);
    checks++;
    if ({count, empty} !== {5'd0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL clean_tentative: got cnt=%0d empty=%b expected 0/1", count, empty);
    end
    applyStimulus(1, 16'hFA03, 4'd3, 0, 0);
    expQ.push_back(16'hFAE0); expQ.push_back(16'hFAE1);
    expQ.push_back(16'hF0E2); expQ.push_back(16'hFA03);
    checks++;
    if ({count, empty} !== {5'd4, 1'b0}) begin
      errors++;
      $display("[TB] FAIL clean_commit: got cnt=%0d empty=%b expected 4/0", count, empty);
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 16'h0, 4'd0, 0, 1);
      expWord = expQ.pop_front();
      checks++;
      if (out_valid !== 1'b1 || out_data !== expWord) begin
        errors++;
        $display("[TB] FAIL clean_read%0d: got v=%b data=%h expected 1/%h", i, out_valid, out_data, expWord);
      end
    end
    checks++;
    if ({count, empty} !== {5'd0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL clean_drained: got cnt=%0d empty=%b expected 0/1", count, empty);
    end
    applyStimulus(0, 16'h0, 4'd0, 0, 1);
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'hFA03) begin
      errors++;
      $display("[TB] FAIL read_empty: got v=%b data=%h expected 0/fa03", out_valid, out_data);
    end
  endtask

  task automatic test_error_frame();
    doReset();
    applyStimulus(1, 16'hF000, 4'd0, 0, 0);
    applyStimulus(1, 16'hF001, 4'd1, 0, 0);
    applyStimulus(1, 16'hF002, 4'd2, 0, 0);
    applyStimulus(1, 16'hF004, 4'd3, 1, 0);
    checks++;
    if ({count, drop_cnt, overflow} !== {5'd0, 8'd1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL error_drop: got cnt=%0d drop=%0d ovf=%b expected 0/1/0", count, drop_cnt, overflow);
    end
    applyStimulus(0, 16'h0, 4'd0, 0, 0);
    applyStimulus(1, 16'hFAE0, 4'd0, 0, 0);
    applyStimulus(1, 16'hFAE1, 4'd1, 0, 0);
    applyStimulus(1, 16'hFAE2, 4'd2, 0, 0);
    applyStimulus(1, 16'h0AE3, 4'd3, 0, 0);
    expQ.push_back(16'hFAE0); expQ.push_back(16'hFAE1);
    expQ.push_back(16'hFAE2); expQ.push_back(16'h0AE3);
    checks++;
    if ({count, drop_cnt} !== {5'd4, 8'd1}) begin
      errors++;
      $display("[TB] FAIL error_recover: got cnt=%0d drop=%0d expected 4/1", count, drop_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 16'h0, 4'd0, 0, 1);
      expWord = expQ.pop_front();
      checks++;
      if (out_valid !== 1'b1 || out_data !== expWord) begin
        errors++;
        $display("[TB] FAIL error_read%0d: got v=%b data=%h expected 1/%h", i, out_valid, out_data, expWord);
      end
    end
  endtask

  task automatic test_seq_break();
    doReset();
    applyStimulus(1, 16'hA000, 4'd0, 0, 0);
    applyStimulus(1, 16'hA001, 4'd1, 0, 0);
    applyStimulus(1, 16'hA003, 4'd3, 0, 0);
    checks++;
    if ({count, drop_cnt} !== {5'd0, 8'd1}) begin
      errors++;
      $display("[TB] FAIL seq_break: got cnt=%0d drop=%0d expected 0/1", count, drop_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 16'hB000 + 16'(i), 4'(i), 0, 0);
      expQ.push_back(16'hB000 + 16'(i));
    end
    checks++;
    if ({count, drop_cnt} !== {5'd4, 8'd1}) begin
      errors++;
      $display("[TB] FAIL seq_restart: got cnt=%0d drop=%0d expected 4/1", count, drop_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 16'h0, 4'd0, 0, 1);
      expWord = expQ.pop_front();
      checks++;
      if (out_valid !== 1'b1 || out_data !== expWord) begin
        errors++;
        $display("[TB] FAIL seq_read%0d: got v=%b data=%h expected 1/%h", i, out_valid, out_data, expWord);
      end
    end
  endtask

  task automatic test_overflow();
    doReset();
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 4; i++) begin
        applyStimulus(1, 16'hC000 + 16'(f * 16 + i), 4'(i), 0, 0);
        expQ.push_back(16'hC000 + 16'(f * 16 + i));
      end
    end
    checks++;
    if ({count, full, empty} !== {5'd16, 1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL ovf_fill: got cnt=%0d full=%b empty=%b expected 16/1/0", count, full, empty);
    end
    applyStimulus(1, 16'hD000, 4'd0, 0, 0);
    checks++;
    if ({overflow, drop_cnt, count} !== {1'b1, 8'd1, 5'd16}) begin
      errors++;
      $display("[TB] FAIL ovf_idle: got ovf=%b drop=%0d cnt=%0d expected 1/1/16", overflow, drop_cnt, count);
    end
    applyStimulus(0, 16'h0, 4'd0, 0, 0);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ovf_pulse: got ovf=%b expected 0", overflow);
    end
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 16'h0, 4'd0, 0, 1);
      expWord = expQ.pop_front();
      checks++;
      if (out_valid !== 1'b1 || out_data !== expWord) begin
        errors++;
        $display("[TB] FAIL ovf_read%0d: got v=%b data=%h expected 1/%h", i, out_valid, out_data, expWord);
      end
    end
    applyStimulus(1, 16'hF000, 4'd0, 0, 0);
    applyStimulus(1, 16'hF001, 4'd1, 0, 0);
    checks++;
    if ({count, full} !== {5'd14, 1'b1}) begin
      errors++;
      $display("[TB] FAIL ovf_partial: got cnt=%0d full=%b expected 14/1", count, full);
    end
    applyStimulus(1, 16'hF002, 4'd2, 0, 0);
    checks++;
    if ({overflow, drop_cnt, count, full} !== {1'b1, 8'd2, 5'd14, 1'b0}) begin
      errors++;
      $display("[TB] FAIL ovf_collect: got ovf=%b drop=%0d cnt=%0d full=%b expected 1/2/14/0",
               overflow, drop_cnt, count, full);
    end
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 16'h0, 4'd0, 0, 1);
      expWord = expQ.pop_front();
      checks++;
      if (out_valid !== 1'b1 || out_data !== expWord) begin
        errors++;
        $display("[TB] FAIL ovf_read%0d: got v=%b data=%h expected 1/%h", i + 2, out_valid, out_data, expWord);
      end
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 16'hE000 + 16'(i), 4'(i), 0, 0);
      expQ.push_back(16'hE000 + 16'(i));
    end
    checks++;
    if ({count, full} !== {5'd16, 1'b1}) begin
      errors++;
      $display("[TB] FAIL ovf_recommit: got cnt=%0d full=%b expected 16/1", count, full);
    end
    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, 16'h0, 4'd0, 0, 1);
      expWord = expQ.pop_front();
      checks++;
      if (out_valid !== 1'b1 || out_data !== expWord) begin
        errors++;
        $display("[TB] FAIL ovf_drain%0d: got v=%b data=%h expected 1/%h", i, out_valid, out_data, expWord);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 16'h5000 + 16'(i), 4'(i), 0, 0);
      expQ.push_back(16'h5000 + 16'(i));
    end
    applyStimulus(0, 16'h0, 4'd0, 0, 1);
    expWord = expQ.pop_front();
    checks++;
    if (out_valid !== 1'b1 || out_data !== expWord) begin
      errors++;
      $display("[TB] FAIL mid_read: got v=%b data=%h expected 1/%h", out_valid, out_data, expWord);
    end
    applyStimulus(1, 16'h6000, 4'd0, 0, 0);
    applyStimulus(1, 16'h6001, 4'd1, 1, 0);
    applyStimulus(1, 16'h7000, 4'd0, 0, 0);
    applyStimulus(1, 16'h7001, 4'd1, 0, 0);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({out_data, out_valid, count, empty, full, drop_cnt, overflow} !== {16'h0, 1'b0, 5'd0, 1'b1, 1'b0, 8'd0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL mid_reset: got data=%h v=%b cnt=%0d e=%b f=%b drop=%0d ovf=%b",
               out_data, out_valid, count, empty, full, drop_cnt, overflow);
    end
    @(negedge clk);
    reset = 1'b0;
    expQ.delete();
    applyStimulus(1, 16'h7002, 4'd2, 0, 0);
    applyStimulus(1, 16'h7003, 4'd3, 0, 0);
    checks++;
    if ({count, drop_cnt} !== {5'd0, 8'd0}) begin
      errors++;
      $display("[TB] FAIL mid_idle_after_reset: got cnt=%0d drop=%0d expected 0/0", count, drop_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 16'h8000 + 16'(i), 4'(i), 0, 0);
      expQ.push_back(16'h8000 + 16'(i));
    end
    checks++;
    if (count !== 5'd4) begin
      errors++;
      $display("[TB] FAIL mid_recommit: got cnt=%0d expected 4", count);
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 16'h0, 4'd0, 0, 1);
      expWord = expQ.pop_front();
      checks++;
      if (out_valid !== 1'b1 || out_data !== expWord) begin
        errors++;
        $display("[TB] FAIL mid_drain%0d: got v=%b data=%h expected 1/%h", i, out_valid, out_data, expWord);
      end
    end
  endtask

  task automatic test_simultaneous();
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 16'h9000 + 16'(i), 4'(i), 0, 0);
      expQ.push_back(16'h9000 + 16'(i));
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 16'h9100 + 16'(i), 4'(i), 0, 0);
      expQ.push_back(16'h9100 + 16'(i));
    end
    expQ.push_back(16'h9103);
    applyStimulus(1, 16'h9103, 4'd3, 0, 1);
    expWord = expQ.pop_front();
    checks++;
    if ({count, out_valid, out_data} !== {5'd7, 1'b1, expWord}) begin
      errors++;
      $display("[TB] FAIL sim_commit_read: got cnt=%0d v=%b data=%h expected 7/1/%h", count, out_valid, out_data, expWord);
    end
    for (int i = 0; i < 7; i++) begin
      applyStimulus(0, 16'h0, 4'd0, 0, 1);
      expWord = expQ.pop_front();
      checks++;
      if (out_valid !== 1'b1 || out_data !== expWord) begin
        errors++;
        $display("[TB] FAIL sim_read%0d: got v=%b data=%h expected 1/%h", i, out_valid, out_data, expWord);
      end
    end
    applyStimulus(0, 16'h0, 4'd0, 0, 0);
    checks++;
    if ({count, empty, out_valid} !== {5'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL sim_drained: got cnt=%0d empty=%b v=%b expected 0/1/0", count, empty, out_valid);
    end
  endtask

  task automatic test_drop_saturation();
    doReset();
    applyStimulus(1, 16'h0, 4'd0, 0, 0);
    for (int i = 0; i < 20; i++) applyStimulus(1, 16'h0, 4'd0, 0, 0);
    checks++;
    if (drop_cnt !== 8'd10) begin
      errors++;
      $display("[TB] FAIL drop_count: got drop=%0d expected 10", drop_cnt);
    end
    for (int i = 0; i < 500; i++) applyStimulus(1, 16'h0, 4'd0, 0, 0);
    checks++;
    if ({drop_cnt, count} !== {8'd255, 5'd0}) begin
      errors++;
      $display("[TB] FAIL drop_saturate: got drop=%0d cnt=%0d expected 255/0", drop_cnt, count);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    test_reset();
    test_clean_frame();
    test_error_frame();
    test_seq_break();
    test_overflow();
    test_reset_mid_frame();
    test_simultaneous();
    test_drop_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
